// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi BER loop: run-controller states,
// the 2-bit channel symbol, and the PRBS generator definition.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] sym_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form: taps on bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/viterbi_ber_delay.sv
// Valid/bit delay line that lines the sent bits up with the decoder output.
// The oldest stage is presented on the tap outputs.
module viterbi_ber_delay
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  input  logic bit_i,
  output logic tap_vld_o,
  output logic tap_bit_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] bit_q, bit_d;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], vld_i};
    bit_d = {bit_q[DEPTH-2:0], bit_i};
  end

  // NOTE: the line is reset because a stale valid bit after reset would count a phantom compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      bit_q <= '0;
    end else begin
      vld_q <= vld_d;
      bit_q <= bit_d;
    end
  end

  assign tap_vld_o = vld_q[DEPTH-1];
  assign tap_bit_o = bit_q[DEPTH-1];

endmodule

// File: rtl/viterbi_ber_ctrl.sv
// Run controller for the encoder -> channel -> decoder BER loop: drives a frame,
// injects symbol errors, and counts decoded bit errors. Define VITERBI_BER_PRBS_EN
// to source the frame from the internal LFSR instead of data_i.
module viterbi_ber_ctrl
  import viterbi_pkg::*;
#(
  parameter int         FRAME_LEN   = 256,
  parameter int         DEC_LAT     = 20,
  parameter int         INJ_PERIOD  = 8,
  parameter int         INJ_LIMIT   = 256,
  parameter logic [1:0] INJ_PATTERN = 2'b01,
  parameter int         CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          data_i,
  output logic          enc_bit_o,
  output logic          enc_en_o,
  input  logic          enc_valid_i,
  output logic [1:0]    err_mask_o,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [CW-1:0] inj_ct_o,
  output logic [CW-1:0] bit_err_ct_o
);

  localparam int CTW = $clog2((FRAME_LEN > DEC_LAT + 1) ? FRAME_LEN : DEC_LAT + 1) + 1;
  localparam int PW  = $clog2(INJ_PERIOD + 1);
  localparam logic [CTW-1:0] LAST_BIT   = CTW'(FRAME_LEN - 1);
  localparam logic [CTW-1:0] LAST_FLUSH = CTW'(DEC_LAT);
  localparam logic [PW-1:0]  PH_LAST    = PW'(INJ_PERIOD - 1);
  localparam logic [CW:0]    INJ_LIM_W  = (INJ_LIMIT >= 2 ** CW) ? {1'b1, {CW{1'b0}}}
                                                                 : (CW + 1)'(INJ_LIMIT);

  state_e        state_q, state_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]  sym_ct_q, sym_ct_d;
  logic [PW-1:0]  ph_q, ph_d;
  logic [CW-1:0]  inj_ct_q, inj_ct_d;
  logic [CW-1:0]  err_ct_q, err_ct_d;
  logic           pass_q, pass_d;
  logic           enc_en_q, enc_en_d;
  logic           enc_bit_q, enc_bit_d;
  logic           src_first, src_next;
  logic           tap_vld, tap_bit;
  sym_t           inj_mask;

`ifdef VITERBI_BER_PRBS_EN
  logic [15:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic        unused_data;

  assign unused_data = data_i;
  assign lfsr_nxt    = lfsr_step(lfsr_q);
  assign src_first   = LFSR_SEED[0];
  assign src_next    = lfsr_nxt[0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && start_i) lfsr_d = LFSR_SEED;
    else if (state_q == RUN)        lfsr_d = lfsr_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= '0;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign src_first = data_i;
  assign src_next  = data_i;
`endif

  // The phase counter stands in for sym_ct % INJ_PERIOD and freezes with sym_ct.
  assign inj_mask = (enc_valid_i && ph_q == PH_LAST && {1'b0, sym_ct_q} < INJ_LIM_W)
                    ? sym_t'(INJ_PATTERN) : sym_t'(2'b00);

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_ct_d  = sym_ct_q;
    ph_d      = ph_q;
    inj_ct_d  = inj_ct_q;
    err_ct_d  = err_ct_q;
    pass_d    = pass_q;
    enc_en_d  = 1'b0;
    enc_bit_d = 1'b0;

    if (busy_o && enc_valid_i && ~&sym_ct_q) begin
      sym_ct_d = sym_ct_q + 1'b1;
      ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
    if (inj_mask != 2'b00 && ~&inj_ct_q) inj_ct_d = inj_ct_q + 1'b1;
    if (tap_vld && (tap_bit != dec_bit_i) && ~&err_ct_q) err_ct_d = err_ct_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          cnt_d     = '0;
          sym_ct_d  = '0;
          ph_d      = '0;
          inj_ct_d  = '0;
          err_ct_d  = '0;
          pass_d    = 1'b0;
          enc_en_d  = 1'b1;
          enc_bit_d = src_first;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          enc_en_d  = 1'b1;
          enc_bit_d = src_next;
        end
      end
      FLUSH: begin
        // The final compare lands on this edge, so pass uses the updated count.
        if (cnt_q == LAST_FLUSH) begin
          state_d = DONE;
          pass_d  = (err_ct_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sym_ct_q  <= '0;
      ph_q      <= '0;
      inj_ct_q  <= '0;
      err_ct_q  <= '0;
      pass_q    <= 1'b0;
      enc_en_q  <= 1'b0;
      enc_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_ct_q  <= sym_ct_d;
      ph_q      <= ph_d;
      inj_ct_q  <= inj_ct_d;
      err_ct_q  <= err_ct_d;
      pass_q    <= pass_d;
      enc_en_q  <= enc_en_d;
      enc_bit_q <= enc_bit_d;
    end
  end

  viterbi_ber_delay #(
    .DEPTH(DEC_LAT + 1)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (enc_en_q),
    .bit_i    (enc_bit_q),
    .tap_vld_o(tap_vld),
    .tap_bit_o(tap_bit)
  );

  assign enc_en_o     = enc_en_q;
  assign enc_bit_o    = enc_bit_q;
  assign err_mask_o   = inj_mask;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = pass_q;
  assign inj_ct_o     = inj_ct_q;
  assign bit_err_ct_o = err_ct_q;

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// Scoreboard bench for viterbi_ber_ctrl: three configurations, an encoder/decoder
// loopback model, and expected run results queued at start and checked at done_o.
module tb_viterbi_ber_ctrl;

  localparam int N = 3;
  localparam int FL[N]  = '{64, 64, 1};
  localparam int DL[N]  = '{20, 20, 1};
  localparam int IP[N]  = '{8, 4, 1};
  localparam int IL[N]  = '{256, 16, 256};
  localparam int HL = 64;

  typedef struct {
    int inst;
    int inj;
    int err;
    int pass;
    int n_en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i[N], data_i[N], enc_valid_i[N], dec_bit_i[N];
  logic        enc_bit_o[N], enc_en_o[N], busy_o[N], done_o[N], pass_o[N];
  logic [1:0]  err_mask_o[N];
  logic [15:0] inj_ct_o[N], bit_err_ct_o[N];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 100;
  int   en_cnt[N], sidx[N], dec_idx[N], flip[N], done_cnt[N];
  bit   pend[N];
  int   pend_pass[N];
  logic en_hist[N][HL], bit_hist[N][HL];
  logic [15:0] lf[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    viterbi_ber_ctrl #(
      .FRAME_LEN(FL[g]), .DEC_LAT(DL[g]), .INJ_PERIOD(IP[g]),
      .INJ_LIMIT(IL[g]), .INJ_PATTERN(2'b01), .CW(16)
    ) u_dut (
      .clk(clk), .rst(rst), .start_i(start_i[g]), .data_i(data_i[g]),
      .enc_bit_o(enc_bit_o[g]), .enc_en_o(enc_en_o[g]), .enc_valid_i(enc_valid_i[g]),
      .err_mask_o(err_mask_o[g]), .dec_bit_i(dec_bit_i[g]), .busy_o(busy_o[g]),
      .done_o(done_o[g]), .pass_o(pass_o[g]), .inj_ct_o(inj_ct_o[g]),
      .bit_err_ct_o(bit_err_ct_o[g])
    );
  end

  task automatic check(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d", nm, i, $time, act, exp);
    end
  endtask

  function automatic int exp_inj(input int i);
    int n = 0;
    for (int k = 0; k < FL[i]; k++)
      if ((k % IP[i]) == IP[i] - 1 && k < IL[i]) n++;
    return n;
  endfunction

  // Encoder (one-cycle valid lag), ideal decoder (DEC_LAT+1 lag) and output monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!rst) begin
          for (int h = 0; h < HL; h++) begin
            en_hist[i][h] = 1'b0;
            bit_hist[i][h] = 1'b0;
          end
          en_cnt[i] = 0; sidx[i] = 0; dec_idx[i] = 0; pend[i] = 1'b0;
          enc_valid_i[i] = 1'b0; dec_bit_i[i] = 1'b0;
          continue;
        end
        if (pend[i]) begin
          check("pass_hold", i, pass_o[i], pend_pass[i]);
          check("done_width", i, done_o[i], 0);
          pend[i] = 1'b0;
        end
        if (enc_en_o[i]) begin
`ifdef VITERBI_BER_PRBS_EN
          check("enc_bit_prbs", i, enc_bit_o[i], lf[i][0]);
          lf[i] = {lf[i][0] ^ lf[i][2] ^ lf[i][3] ^ lf[i][5], lf[i][15:1]};
`else
          check("enc_bit", i, enc_bit_o[i], data_i[i]);
`endif
          en_cnt[i]++;
        end
        if (done_o[i]) begin
          done_cnt[i]++;
          if (sb.size() == 0) begin
            check("unexpected_done", i, 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_inst", i, i, e.inst);
            check("inj_ct", i, inj_ct_o[i], e.inj);
            check("bit_err_ct", i, bit_err_ct_o[i], e.err);
            check("pass", i, pass_o[i], e.pass);
            check("enc_en_cycles", i, en_cnt[i], e.n_en);
            check("busy_in_done", i, busy_o[i], 1);
            pend[i] = 1'b1;
            pend_pass[i] = e.pass;
          end
        end
        data_i[i] = 1'($urandom_range(0, 1));
        en_hist[i][cyc % HL]  = enc_en_o[i];
        bit_hist[i][cyc % HL] = enc_bit_o[i];
        enc_valid_i[i] = en_hist[i][(cyc - 1) % HL];
        begin
          int   t;
          logic d;
          t = (cyc - DL[i] - 1) % HL;
          d = bit_hist[i][t];
          if (en_hist[i][t]) begin
            if (dec_idx[i] == flip[i]) d = ~d;
            dec_idx[i]++;
          end
          dec_bit_i[i] = d;
        end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          logic [1:0] em;
          em = (enc_valid_i[i] && (sidx[i] % IP[i]) == IP[i] - 1 && sidx[i] < IL[i]) ? 2'b01 : 2'b00;
          check("err_mask", i, err_mask_o[i], em);
          if (enc_valid_i[i] && busy_o[i]) sidx[i]++;
        end
      end
    end
  end

  task automatic begin_run(input int i, input int flp);
    exp_t e;
    int   ne;
    @(posedge clk); #2;
    start_i[i] = 1'b1;
    en_cnt[i] = 0; sidx[i] = 0; dec_idx[i] = 0; flip[i] = flp; lf[i] = 16'hACE1;
    ne = (flp >= 0 && flp < FL[i]) ? 1 : 0;
    e = '{inst: i, inj: exp_inj(i), err: ne, pass: (ne == 0) ? 1 : 0, n_en: FL[i]};
    sb.push_back(e);
  endtask

  task automatic wait_done(input int i, input int d0, input int budget);
    int k = 0;
    while (done_cnt[i] == d0 && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (done_cnt[i] == d0) check("done_timeout", i, 0, 1);
  endtask

  task automatic run(input int i, input int flp, input bit hold);
    int d0;
    d0 = done_cnt[i];
    begin_run(i, flp);
    if (!hold) begin
      @(posedge clk); #2;
      start_i[i] = 1'b0;
    end
    wait_done(i, d0, FL[i] + DL[i] + 20);
    start_i[i] = 1'b0;
  endtask

  initial begin
    int d0, k;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      start_i[i] = 1'b0; data_i[i] = 1'b0; enc_valid_i[i] = 1'b0; dec_bit_i[i] = 1'b0;
      done_cnt[i] = 0; flip[i] = -1; lf[i] = 16'hACE1; pend[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      check("rst_busy", i, busy_o[i], 0);
      check("rst_done", i, done_o[i], 0);
      check("rst_pass", i, pass_o[i], 0);
      check("rst_enc_en", i, enc_en_o[i], 0);
      check("rst_enc_bit", i, enc_bit_o[i], 0);
      check("rst_inj_ct", i, inj_ct_o[i], 0);
      check("rst_err_ct", i, bit_err_ct_o[i], 0);
    end
    rst = 1'b1;

    run(0, -1, 1'b0);
    run(0, 10, 1'b0);
    run(1, -1, 1'b0);
    run(2, -1, 1'b0);
    run(2, 0, 1'b0);

    // start_i held through the whole run, including FLUSH
    d0 = done_cnt[0];
    run(0, -1, 1'b1);
    repeat (FL[0] + DL[0] + 10) @(posedge clk);
    #2;
    check("single_run_on_hold", 0, done_cnt[0] - d0, 1);
    check("idle_after_hold", 0, busy_o[0], 0);

    // reset in mid-RUN
    begin_run(0, -1);
    @(posedge clk); #2;
    start_i[0] = 1'b0;
    k = 0;
    while (en_cnt[0] < 30 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    check("reach_bit30", 0, (en_cnt[0] >= 30) ? 1 : 0, 1);
    d0 = done_cnt[0];
    #1 rst = 1'b0;
    #1;
    check("arst_busy", 0, busy_o[0], 0);
    check("arst_enc_en", 0, enc_en_o[0], 0);
    check("arst_enc_bit", 0, enc_bit_o[0], 0);
    check("arst_done", 0, done_o[0], 0);
    check("arst_inj_ct", 0, inj_ct_o[0], 0);
    check("arst_err_ct", 0, bit_err_ct_o[0], 0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (FL[0] + DL[0] + 10) @(posedge clk);
    #2;
    check("no_done_after_rst", 0, done_cnt[0] - d0, 0);

    run(0, -1, 1'b0);
    run(0, 33, 1'b0);
    check("sb_drained", 0, sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_ctrl.md
Name: viterbi_ber_ctrl

Overview:
Run controller for the Viterbi encoder → channel → decoder loop.
- On start, drives a frame of source bits plus the encoder enable.
- Drives a per-symbol 2-bit error-injection mask that the channel XORs onto encoder output symbols.
- Aligns decoder output against a delayed copy of the sent bits and counts bit errors.
- Ends each run with a done pulse and pass/fail status.
- Replaces ad-hoc word-count injection logic in the tx/rx top; instantiated beside encoder and decoder.

Parameters:
FRAME_LEN, 256, source bits per run (≥1)
DEC_LAT, 20, cycles from decoder input symbol to matching decoder output bit (≥1)
INJ_PERIOD, 8, inject on every INJ_PERIOD-th encoder symbol (≥1)
INJ_LIMIT, 256, no injection on symbols with index ≥ INJ_LIMIT
INJ_PATTERN, 2'b01, mask applied on injecting symbols
CW, 16, status counter width

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  start a run; sampled only in IDLE
data_i  in  1  source bit when PRBS disabled
enc_bit_o  out  1  bit to encoder d_in
enc_en_o  out  1  encoder enable_i
enc_valid_i  in  1  encoder valid_o
err_mask_o  out  2  XOR mask for the current encoder symbol
dec_bit_i  in  1  decoder d_out
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at end of run
pass_o  out  1  bit_err_ct_o==0; valid from done_o onward
inj_ct_o  out  CW  injected symbols this run
bit_err_ct_o  out  CW  mismatched decoded bits this run

Behaviour:
- Reset: rst is asynchronous, active-low; clk is the clock. All regs clear.
  - State IDLE; all outputs 0, except pass_o=0.
  - Delay line and counters cleared.
- FSM: IDLE → RUN → FLUSH → DONE → IDLE.
  - IDLE: start_i=1 → RUN next cycle. Clears bit_ct, sym_ct, inj_ct_o, bit_err_ct_o and pass_o on that edge. busy_o=0.
  - RUN: enc_en_o=1 for exactly FRAME_LEN consecutive cycles. enc_bit_o registered, new bit each cycle. bit_ct counts 0..FRAME_LEN-1. Last bit → FLUSH.
  - FLUSH: enc_en_o=0, enc_bit_o=0. Held for DEC_LAT+1 cycles (covers the encoder→decoder register stage). Then → DONE.
  - DONE: done_o=1 for one cycle, pass_o updated, → IDLE.
  - busy_o=1 in RUN, FLUSH and DONE.
- start_i outside IDLE: ignored (no restart, no queueing).
- Injection:
  - err_mask_o is combinational: INJ_PATTERN when enc_valid_i && (sym_ct % INJ_PERIOD == INJ_PERIOD-1) && sym_ct < INJ_LIMIT, else 2'b00.
  - sym_ct increments on each enc_valid_i while busy.
  - inj_ct_o increments on each cycle err_mask_o≠0.
- Checking:
  - Shift register, depth DEC_LAT+1, of {enc_en_o, enc_bit_o}.
  - When the tap valid bit is 1, compare dec_bit_i to the tap bit; on mismatch bit_err_ct_o += 1.
  - Exactly FRAME_LEN compares per run. The tap drains fully by the end of FLUSH.
- Counters saturate at all-ones; no wrap.
- FRAME_LEN=1: RUN lasts one cycle; normal flow otherwise.
- INJ_PERIOD=1: every symbol below INJ_LIMIT is injected.
- Reset mid-run: immediate IDLE, outputs and counters zero, no done_o.

Optional Feature:
VITERBI_BER_PRBS_EN
- Defined:
  - enc_bit_o comes from an internal 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1, reloaded on each start; advances once per RUN cycle; output = LFSR[0].
  - data_i is ignored.
- Not defined: enc_bit_o = data_i registered during RUN.
- Port list is identical either way.

Decomposition:
- Package viterbi_pkg:
  - state enum typedef (IDLE, RUN, FLUSH, DONE)
  - LFSR seed and tap constants
  - 2-bit symbol typedef shared with encoder/decoder
- One natural sub-module: viterbi_ber_delay (parameterised depth DEC_LAT+1 valid/bit delay line with tap outputs).
- FSM and counters stay in the top.

Test Plan:
1. FRAME_LEN=64, INJ_PERIOD=8, INJ_PATTERN=01, ideal loopback model (dec_bit_i = enc_bit_o delayed DEC_LAT+1 cycles), pulse start_i → enc_en_o high exactly 64 cycles, inj_ct_o=8, bit_err_ct_o=0, done_o single pulse, pass_o=1.
2. Same as 1, but the model inverts the decoded bit for output index 10 → bit_err_ct_o=1, pass_o=0 at done_o.
3. INJ_LIMIT=16, FRAME_LEN=64, INJ_PERIOD=4 → inj_ct_o=4; err_mask_o=00 on all symbols ≥16.
4. start_i held high for the whole run, plus an extra pulse during FLUSH → exactly one run, one done_o; next run only after return to IDLE.
5. Assert rst low in mid-RUN (bit 30) → all outputs 0 asynchronously, no done_o. A subsequent start gives a full clean run matching scenario 1.
6. PRBS_EN defined → first 16 enc_bit_o values match the reference LFSR from seed ACE1; identical sequence on a second run.
